// File: rtl/tri_pkg.sv
// -----------------------------------------------------------------------------
// tri_pkg
// Shared definitions for the triangular accumulator family (forward block and
// tri_root_extract). Holds the FSM state encoding, the default WIDTH/LIMIT
// constants and the value typedef.
// No ports (package).
// -----------------------------------------------------------------------------
package tri_pkg;

    localparam int TRI_WIDTH = 15;
    localparam int TRI_LIMIT = 200;

    typedef logic [TRI_WIDTH-1:0] tri_value_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } tri_state_t;

endpackage

// File: rtl/tri_root_extract_if.sv
// -----------------------------------------------------------------------------
// tri_root_extract_if
// Groups the request/response handshake, the step enable and the result bus
// of tri_root_extract.
//   master : requester/consumer side (drives en, in_valid, in_x, out_ready)
//   slave  : the extractor itself
// Handshake rule: a transfer happens on a rising clk edge where valid and
// ready are both high; valid, once raised, holds its payload until that edge.
// Optional macro TRI_ROOT_EXACT_EN adds the out_exact result bit.
// -----------------------------------------------------------------------------
interface tri_root_extract_if #(
    parameter int WIDTH = tri_pkg::TRI_WIDTH
);
    logic             en;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_x;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic [WIDTH-1:0] out_rem;
    logic             out_err;
    logic             out_sat;
`ifdef TRI_ROOT_EXACT_EN
    logic             out_exact;
`endif

    modport master (
`ifdef TRI_ROOT_EXACT_EN
        input  out_exact,
`endif
        output en, in_valid, in_x, out_ready,
        input  in_ready, out_valid, out_y, out_rem, out_err, out_sat
    );

    modport slave (
`ifdef TRI_ROOT_EXACT_EN
        output out_exact,
`endif
        input  en, in_valid, in_x, out_ready,
        output in_ready, out_valid, out_y, out_rem, out_err, out_sat
    );

endinterface

// File: rtl/tri_step.sv
// -----------------------------------------------------------------------------
// tri_step
// Combinational datapath for one accumulate step of the inverse search.
//   i_acc  : current accumulator (1 + k(k-1)/2)
//   i_k    : current step count
//   i_v    : target value being inverted
//   o_sum  : acc + k, the accumulator value after a step (valid when o_go)
//   o_go   : another step still fits and k is below LIMIT
//   o_sat  : k reached LIMIT although another step would still have fit
// -----------------------------------------------------------------------------
module tri_step
    import tri_pkg::*;
#(
    parameter int WIDTH = TRI_WIDTH,
    parameter int LIMIT = TRI_LIMIT
) (
    input  logic [WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0] i_k,
    input  logic [WIDTH-1:0] i_v,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_go,
    output logic             o_sat
);

    localparam logic [WIDTH-1:0] LIMIT_V = WIDTH'(LIMIT);

    logic [WIDTH:0] w_sum_wide;
    logic           w_fits;

    // One extra bit so acc+k cannot wrap when v sits near the top of range.
    assign w_sum_wide = {1'b0, i_acc} + {1'b0, i_k};
    assign w_fits     = (w_sum_wide <= {1'b0, i_v});
    assign o_sum      = w_sum_wide[WIDTH-1:0];
    assign o_go       = (i_k < LIMIT_V) && w_fits;
    assign o_sat      = (i_k == LIMIT_V) && w_fits;

endmodule

// File: rtl/tri_root_extract.sv
// -----------------------------------------------------------------------------
// tri_root_extract
// Inverse of the triangular accumulator: given a final accumulator value x,
// finds the largest step count k <= LIMIT with 1 + k(k-1)/2 <= x and the
// leftover x - (1 + k(k-1)/2). Walks the forward recurrence one step per
// enabled cycle.
// Ports:
//   clk          : clock
//   rst          : synchronous, active-high reset
//   bus          : tri_root_extract_if.slave (en, request, response, results)
//   o_dbg_state  : current FSM state, for observation only
// Optional macro TRI_ROOT_EXACT_EN adds bus.out_exact (remainder is zero and
// no error).
// -----------------------------------------------------------------------------
module tri_root_extract
    import tri_pkg::*;
#(
    parameter int WIDTH = TRI_WIDTH,
    parameter int LIMIT = TRI_LIMIT
) (
    input  logic                clk,
    input  logic                rst,
    tri_root_extract_if.slave   bus,
    output tri_state_t          o_dbg_state
);

    tri_state_t       r_state;
    tri_state_t       w_state_nxt;

    logic [WIDTH-1:0] r_v;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_k;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_rem;
    logic             r_err;
    logic             r_sat;
`ifdef TRI_ROOT_EXACT_EN
    logic             r_exact;
`endif

    logic [WIDTH-1:0] w_sum;
    logic             w_go;
    logic             w_sat;
    logic             w_err;
    logic             w_accept;
    logic             w_step;

    tri_step #(
        .WIDTH (WIDTH),
        .LIMIT (LIMIT)
    ) u_step (
        .i_acc (r_acc),
        .i_k   (r_k),
        .i_v   (r_v),
        .o_sum (w_sum),
        .o_go  (w_go),
        .o_sat (w_sat)
    );

    assign w_accept = (r_state == ST_IDLE) && bus.in_valid;
    assign w_step   = (r_state == ST_RUN) && bus.en;
    // k==0 at termination means even acc=1 exceeded v, i.e. v was 0.
    assign w_err    = (r_k == '0);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.en && !w_go) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v   <= '0;
            r_acc <= '0;
            r_k   <= '0;
            r_y   <= '0;
            r_rem <= '0;
            r_err <= 1'b0;
            r_sat <= 1'b0;
`ifdef TRI_ROOT_EXACT_EN
            r_exact <= 1'b0;
`endif
        end else if (w_accept) begin
            r_v   <= bus.in_x;
            r_acc <= WIDTH'(1);
            r_k   <= '0;
        end else if (w_step) begin
            if (w_go) begin
                r_acc <= w_sum;
                r_k   <= r_k + WIDTH'(1);
            end else begin
                // Final step: results stay put until the next transaction ends.
                r_y   <= r_k;
                r_err <= w_err;
                r_rem <= w_err ? '0 : (r_v - r_acc);
                r_sat <= w_sat;
`ifdef TRI_ROOT_EXACT_EN
                r_exact <= !w_err && (r_v == r_acc);
`endif
            end
        end
    end

    // ---------------- Outputs ----------------
    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.out_y     = r_y;
    assign bus.out_rem   = r_rem;
    assign bus.out_err   = r_err;
    assign bus.out_sat   = r_sat;
`ifdef TRI_ROOT_EXACT_EN
    assign bus.out_exact = r_exact;
`endif
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_tri_root_extract.sv
// -----------------------------------------------------------------------------
// tb_tri_root_extract
// Directed and randomized checks of tri_root_extract against a reference
// search over the triangular sequence 1 + k(k-1)/2.
// -----------------------------------------------------------------------------
module tb_tri_root_extract;
    import tri_pkg::*;

    localparam int W   = TRI_WIDTH;
    localparam int LIM = TRI_LIMIT;

    logic       clk;
    logic       rst;
    tri_state_t dbg_state;
    int         checks;
    int         errors;

    tri_root_extract_if #(.WIDTH(W)) bus ();

    tri_root_extract #(
        .WIDTH (W),
        .LIMIT (LIM)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: scan k downward, first triangular value that fits wins.
    function automatic void ref_model(input int x, output int y, output int rem,
                                      output int err, output int sat);
        int t;
        y = 0; rem = 0; err = 1; sat = 0;
        for (int k = LIM; k >= 0; k--) begin
            t = 1 + (k * (k - 1)) / 2;
            if (t <= x) begin
                y   = k;
                rem = x - t;
                err = 0;
                break;
            end
        end
        if (!err && y == LIM && (1 + (LIM * (LIM + 1)) / 2) <= x) sat = 1;
    endfunction

    // ---------------- driver ----------------
    // Called just after a rising edge with the DUT idle. exp_lat < 0 derives
    // latency from the en pattern: y+1 enabled edges are needed.
    task automatic do_txn(input int x, input bit toggle_en, input int hold,
                          input int exp_lat, input string tag);
        int y, rem, err, sat, lat, cycles;
        logic [W-1:0] sy, srem;
        ref_model(x, y, rem, err, sat);
        lat = (exp_lat >= 0) ? exp_lat : (toggle_en ? 2 * y + 1 : y + 1);
        bus.out_ready = (hold == 0);
        bus.in_valid  = 1'b1;
        bus.in_x      = W'(x);
        bus.en        = 1'b1;
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.in_x      = '0;
        chk({tag, ".busy_ready"}, bus.in_ready, 0);
        cycles = 0;
        while (!bus.out_valid && cycles < LIM * 2 + 20) begin
            bus.en = toggle_en ? ((cycles % 2) == 0) : 1'b1;
            @(posedge clk); #1;
            cycles++;
        end
        bus.en = 1'b1;
        chk({tag, ".valid"}, bus.out_valid, 1);
        chk({tag, ".latency"}, cycles, lat);
        chk({tag, ".y"}, bus.out_y, y);
        chk({tag, ".rem"}, bus.out_rem, rem);
        chk({tag, ".err"}, bus.out_err, err);
        chk({tag, ".sat"}, bus.out_sat, sat);
`ifdef TRI_ROOT_EXACT_EN
        chk({tag, ".exact"}, bus.out_exact, (rem == 0 && err == 0));
`endif
        sy   = bus.out_y;
        srem = bus.out_rem;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, ".hold_valid"}, bus.out_valid, 1);
            chk({tag, ".hold_ready"}, bus.in_ready, 0);
            chk({tag, ".hold_y"}, bus.out_y, sy);
            chk({tag, ".hold_rem"}, bus.out_rem, srem);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, ".handoff_valid"}, bus.out_valid, 0);
        chk({tag, ".handoff_ready"}, bus.in_ready, 1);
        chk({tag, ".kept_y"}, bus.out_y, y);
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, ".in_ready"}, bus.in_ready, 1);
        chk({tag, ".out_valid"}, bus.out_valid, 0);
        chk({tag, ".state"}, dbg_state, ST_IDLE);
        chk({tag, ".y"}, bus.out_y, 0);
        chk({tag, ".rem"}, bus.out_rem, 0);
        chk({tag, ".err"}, bus.out_err, 0);
        chk({tag, ".sat"}, bus.out_sat, 0);
`ifdef TRI_ROOT_EXACT_EN
        chk({tag, ".exact"}, bus.out_exact, 0);
`endif
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int x, k;
        bit tg;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.en = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_x = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_cleared("reset");

        // Directed cases
        do_txn(11,    1'b0, 0, 6,   "x11");
        do_txn(20,    1'b0, 0, -1,  "x20");
        do_txn(1,     1'b0, 0, 2,   "x1");
        do_txn(0,     1'b0, 0, 1,   "x0");
        do_txn(19901, 1'b0, 0, -1,  "x19901");
        do_txn(32767, 1'b0, 0, 201, "x32767");
        do_txn(20,    1'b1, 0, 13,  "x20_entoggle");
        do_txn(20,    1'b0, 5, -1,  "x20_stall");

        // Reset during the 3rd RUN cycle of x=11
        bus.in_valid = 1'b1;
        bus.in_x = W'(11);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_cleared("rst_mid_run");
        do_txn(16, 1'b0, 0, -1, "x16_after_rst");

        // Reset and request together: request must be dropped
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_x = W'(50);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        chk_cleared("rst_with_valid");
        @(posedge clk); #1;
        chk("rst_with_valid.still_idle", dbg_state, ST_IDLE);

        // Randomized: full range, small values, and exact triangular hits
        for (int n = 0; n < 30; n++) begin
            case (n % 3)
                0: x = $urandom_range(0, (1 << W) - 1);
                1: x = $urandom_range(0, 300);
                default: begin
                    k = $urandom_range(0, LIM);
                    x = 1 + (k * (k - 1)) / 2 + $urandom_range(0, 1);
                end
            endcase
            tg = 1'($urandom_range(0, 1));
            do_txn(x, tg, $urandom_range(0, 3), -1, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
